mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit bridging the pipeline's memory stage to a ready/valid memory bus.
// Handles byte-lane alignment, load extension, bus timeout and the pipeline stall.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        load_signed,
  output logic [31:0] Mem_data,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    lat_off, lat_size;
  logic          lat_signed, lat_write, lat_to;

  logic          align_ok, req_valid, req_err, timeout_hit;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt, shifted, load_val;

  always_comb begin
    align_ok  = 1'b0;
    be_nxt    = '0;
    wdata_nxt = '0;
    case (size)
      2'b00: begin
        align_ok  = 1'b1;
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'b01: begin
        align_ok  = ~addr[0];
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{wdata[15:0]}};
      end
      2'b10: begin
        align_ok  = (addr[1:0] == 2'b00);
        be_nxt    = 4'b1111;
        wdata_nxt = wdata;
      end
      default: align_ok = 1'b0;
    endcase
    req_valid = (MemRead ^ MemWrite) & align_ok;
    req_err   = (MemRead | MemWrite) & ~req_valid;
  end

  // Right-justify the addressed lanes, then truncate/extend to the latched size.
  always_comb begin
    shifted = bus_rdata >> {lat_off, 3'b000};
    case (lat_size)
      2'b00:   load_val = {{24{lat_signed & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{lat_signed & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    mem_err   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          mem_stall = 1'b1;
          state_nxt = BUSY;
        end else if (req_err) begin
          mem_err = 1'b1;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (bus_ready || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        mem_done  = 1'b1;
        mem_err   = lat_to;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      Mem_data   <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      lat_off    <= '0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_write  <= 1'b0;
      lat_to     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt        <= '0;
            bus_req    <= 1'b1;
            bus_we     <= MemWrite;
            bus_addr   <= {addr[31:2], 2'b00};
            bus_be     <= be_nxt;
            bus_wdata  <= wdata_nxt;
            lat_off    <= addr[1:0];
            lat_size   <= size;
            lat_signed <= load_signed;
            lat_write  <= MemWrite;
            lat_to     <= 1'b0;
          end
        end
        BUSY: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            if (!lat_write) Mem_data <= load_val;
          end else if (timeout_hit) begin
            bus_req  <= 1'b0;
            Mem_data <= '0;
            lat_to   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scenario bench for mem_access_unit: drives CPU requests and a bus responder,
// predicting each access's outcome into a scoreboard queue checked at completion.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite, load_signed;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [31:0] Mem_data;
  logic        mem_stall, mem_done, mem_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .size(size), .load_signed(load_signed),
    .Mem_data(Mem_data), .mem_stall(mem_stall), .mem_done(mem_done), .mem_err(mem_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  be;
    logic        we;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        req_err;
    logic        req_stall;
    int          stall_cycles;
    int          req_cycles;
    logic        stable;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  be;
    logic        we;
    logic        done_seen;
    int          done_cycle;
    int          done_count;
    logic        err_at_done;
    logic [31:0] data;
  } obs_t;

  exp_t sb[$];

  // Drives one request and a bus that answers in BUSY cycle ready_after (0 = never);
  // records what the DUT did for the calling scenario to check.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] sz, input logic sgn,
                            input logic [31:0] rdata, input int ready_after, output obs_t o);
    o = '0;
    o.stable = 1'b1;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; addr = a; wdata = wd; size = sz; load_signed = sgn;
    bus_rdata = rdata; bus_ready = 1'b0;
    @(negedge clk);
    o.req_err = mem_err;
    o.req_stall = mem_stall;
    o.stall_cycles = int'(mem_stall);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      bus_ready = (ready_after != 0) && (k == ready_after);
      @(negedge clk);
      if (mem_stall) o.stall_cycles++;
      if (bus_req) begin
        if (o.req_cycles == 0) begin
          o.baddr = bus_addr; o.bwdata = bus_wdata; o.be = bus_be; o.we = bus_we;
        end else if (bus_addr !== o.baddr || bus_wdata !== o.bwdata || bus_be !== o.be || bus_we !== o.we) begin
          o.stable = 1'b0;
        end
        o.req_cycles++;
      end
      if (mem_done) begin
        o.done_count++;
        if (!o.done_seen) begin
          o.done_seen = 1'b1; o.done_cycle = k; o.err_at_done = mem_err; o.data = Mem_data;
        end
      end
    end
    bus_ready = 1'b0;
  endtask

  task automatic check_access(input string name, input obs_t o, input int exp_lat, input int exp_stall);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (o.done_seen !== 1'b1 || o.done_count != 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d required 1", name, o.done_count);
    end
    n_checks++;
    if (o.done_cycle != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d required %0d", name, o.done_cycle, exp_lat);
    end
    n_checks++;
    if (o.data !== e.data) begin
      n_fail++; $display("FAIL %s Mem_data: got %h required %h", name, o.data, e.data);
    end
    n_checks++;
    if (o.be !== e.be || o.we !== e.we || o.baddr !== e.baddr) begin
      n_fail++; $display("FAIL %s bus_ctl: got be=%b we=%b addr=%h required be=%b we=%b addr=%h",
                         name, o.be, o.we, o.baddr, e.be, e.we, e.baddr);
    end
    if (e.we) begin
      n_checks++;
      if (o.bwdata !== e.bwdata) begin
        n_fail++; $display("FAIL %s bus_wdata: got %h required %h", name, o.bwdata, e.bwdata);
      end
    end
    n_checks++;
    if (o.err_at_done !== e.err) begin
      n_fail++; $display("FAIL %s err_at_done: got %b required %b", name, o.err_at_done, e.err);
    end
    n_checks++;
    if (o.stall_cycles != exp_stall || !o.stable) begin
      n_fail++; $display("FAIL %s stall/stable: got %0d/%b required %0d/1", name, o.stall_cycles, o.stable, exp_stall);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    MemRead = 0; MemWrite = 0; addr = '0; wdata = '0; size = '0; load_signed = 0;
    bus_ready = 0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, bus_be, mem_stall, mem_done, mem_err} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctl: got req=%b we=%b be=%b stall=%b done=%b err=%b required all 0",
                         bus_req, bus_we, bus_be, mem_stall, mem_done, mem_err);
    end
    n_checks++;
    if (Mem_data !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got data=%h addr=%h wdata=%h required 0", Mem_data, bus_addr, bus_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lb_signed();
    obs_t o;
    sb.push_back('{data: 32'hFFFFFF80, baddr: 32'h1000, bwdata: '0, be: 4'b1000, we: 1'b0, err: 1'b0});
    run_access(1, 0, 32'h1003, 32'h0, 2'b00, 1, 32'h80112233, 2, o);
    check_access("lb_signed", o, 3, 3);
  endtask

  task automatic test_sh_store();
    obs_t o;
    sb.push_back('{data: 32'hFFFFFF80, baddr: 32'h2000, bwdata: 32'hABCDABCD, be: 4'b1100, we: 1'b1, err: 1'b0});
    run_access(0, 1, 32'h2002, 32'h0000ABCD, 2'b01, 0, 32'hDEADBEEF, 1, o);
    check_access("sh_store", o, 2, 2);
  endtask

  task automatic test_lhu_min_latency();
    obs_t o;
    sb.push_back('{data: 32'h0000BEEF, baddr: 32'h0, bwdata: '0, be: 4'b1100, we: 1'b0, err: 1'b0});
    run_access(1, 0, 32'h0002, 32'h0, 2'b01, 0, 32'hBEEF1234, 1, o);
    check_access("lhu", o, 2, 2);
  endtask

  task automatic test_errors();
    obs_t o;
    logic [1:0] rw [2] = '{2'b10, 2'b11};
    logic [31:0] ad [2] = '{32'h0006, 32'h0010};
    for (int i = 0; i < 2; i++) begin
      run_access(rw[i][1], rw[i][0], ad[i], 32'h0, 2'b10, 0, 32'h0, 1, o);
      n_checks++;
      if (o.req_err !== 1'b1 || o.req_stall !== 1'b0) begin
        n_fail++; $display("FAIL err_req%0d: got err=%b stall=%b required err=1 stall=0", i, o.req_err, o.req_stall);
      end
      n_checks++;
      if (o.req_cycles != 0 || o.done_seen) begin
        n_fail++; $display("FAIL err_nobus%0d: got req_cycles=%0d done=%b required 0/0", i, o.req_cycles, o.done_seen);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    sb.push_back('{data: 32'h0, baddr: 32'h40, bwdata: '0, be: 4'b1111, we: 1'b0, err: 1'b1});
    run_access(1, 0, 32'h0040, 32'h0, 2'b10, 0, 32'h55555555, 0, o);
    n_checks++;
    if (o.req_cycles != 4) begin
      n_fail++; $display("FAIL timeout_req_cycles: got %0d required 4", o.req_cycles);
    end
    check_access("timeout", o, 5, 5);
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] t_addr  [4] = '{32'h0100, 32'h0101, 32'h0102, 32'h0104};
    logic [31:0] t_wdata [4] = '{32'h0, 32'h0, 32'h0000005A, 32'h0};
    logic [31:0] t_rdata [4] = '{32'h00008001, 32'h0000AB00, 32'h0, 32'hCAFEF00D};
    logic [1:0]  t_size  [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
    logic        t_wr    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        t_sgn   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_exp   [4] = '{32'hFFFF8001, 32'h000000AB, 32'h000000AB, 32'hCAFEF00D};
    logic [3:0]  t_be    [4] = '{4'b0011, 4'b0010, 4'b0100, 4'b1111};
    logic [31:0] t_bw    [4] = '{32'h0, 32'h0, 32'h5A5A5A5A, 32'h0};
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{data: t_exp[i], baddr: {t_addr[i][31:2], 2'b00}, bwdata: t_bw[i],
                     be: t_be[i], we: t_wr[i], err: 1'b0});
      run_access(~t_wr[i], t_wr[i], t_addr[i], t_wdata[i], t_size[i], t_sgn[i], t_rdata[i], i + 1, o);
      check_access($sformatf("b2b%0d", i), o, i + 2, i + 2);
    end
  endtask

  task automatic test_reset_mid_busy();
    obs_t o;
    logic seen;
    @(posedge clk); #1;
    MemRead = 1; MemWrite = 0; addr = 32'h0200; size = 2'b10; load_signed = 0; bus_ready = 0;
    @(posedge clk); #1;
    MemRead = 0;
    @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_busy_pre: got bus_req=%b required 1", bus_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || mem_stall !== 1'b0 || Mem_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_busy_drop: got req=%b stall=%b data=%h required 0/0/0", bus_req, mem_stall, Mem_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_ready = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_done || mem_err || bus_req) seen = 1'b1;
    end
    bus_ready = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy_quiet: got activity=%b required 0", seen);
    end
    sb.push_back('{data: 32'h12345678, baddr: 32'h0300, bwdata: '0, be: 4'b1111, we: 1'b0, err: 1'b0});
    run_access(1, 0, 32'h0300, 32'h0, 2'b10, 0, 32'h12345678, 1, o);
    check_access("post_reset_lw", o, 2, 2);
  endtask

  initial begin
    test_reset();
    test_lb_signed();
    test_sh_store();
    test_errors();
    test_lhu_min_latency();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
